// File: rtl/node_update_scheduler.sv
// Node update scheduler: sweeps nodes, hands each to an update unit and writes back the result.
// Optional macro NODE_SCHED_SKIP_FIXED_EN: nodes pinned by fixed_mask are skipped.
module node_update_scheduler #(
  parameter int unsigned width         = 32,
  parameter int unsigned node_contains = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               iterations,
  input  logic [node_contains-1:0] fixed_mask,
  output logic [width-1:0]         selector,
  output logic                     upd_valid,
  input  logic                     upd_ready,
  input  logic                     res_valid,
  input  logic [width-1:0]         res_x,
  input  logic [width-1:0]         res_y,
  output logic                     wr_en,
  output logic [7:0]               wr_node,
  output logic [width-1:0]         wr_x,
  output logic [width-1:0]         wr_y,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               sweep_cnt
);

  localparam int unsigned NODE_W = 8;

`ifdef NODE_SCHED_SKIP_FIXED_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Lowest eligible node index >= start_idx; MSB flags whether one was found.
  function automatic logic [NODE_W:0] f_find(input logic [node_contains-1:0] elig,
                                             input logic [NODE_W-1:0]        start_idx);
    logic [NODE_W:0] res;
    res = '0;
    for (int i = int'(node_contains) - 1; i >= 0; i--) begin
      if (elig[i] && (NODE_W'(i) >= start_idx)) res = {1'b1, NODE_W'(i)};
    end
    return res;
  endfunction

  state_t                   r_state, w_state_nxt;
  logic [NODE_W-1:0]        r_node, w_node_nxt;
  logic [7:0]               r_sweep, w_sweep_nxt;
  logic [7:0]               r_iter;
  logic [node_contains-1:0] r_fixed;
  logic                     w_latch;

  logic [width-1:0]         r_selector;
  logic                     r_upd_valid, r_wr_en, r_busy, r_done;
  logic [7:0]               r_wr_node;
  logic [width-1:0]         r_wr_x, r_wr_y;

  logic [node_contains-1:0] w_elig_start, w_elig_run;
  logic [NODE_W:0]          w_hit_start, w_hit_next, w_hit_first;
  logic                     w_last_sweep;

  // Fixed nodes are only masked out when the skip feature is built in.
  assign w_elig_start = ~(fixed_mask & {node_contains{SKIP_EN}});
  assign w_elig_run   = ~(r_fixed & {node_contains{SKIP_EN}});
  assign w_hit_start  = f_find(w_elig_start, '0);
  assign w_hit_first  = f_find(w_elig_run, '0);
  assign w_hit_next   = f_find(w_elig_run, NODE_W'(r_node + NODE_W'(1)));
  assign w_last_sweep = (r_sweep == 8'(r_iter - 8'd1));

  always_comb begin
    w_state_nxt = r_state;
    w_node_nxt  = r_node;
    w_sweep_nxt = r_sweep;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sweep_nxt = '0;
          w_latch     = 1'b1;
          if ((iterations != 8'd0) && w_hit_start[NODE_W]) begin
            w_node_nxt  = w_hit_start[NODE_W-1:0];
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_ISSUE: if (upd_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (res_valid) w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (w_hit_next[NODE_W]) begin
          w_node_nxt  = w_hit_next[NODE_W-1:0];
          w_state_nxt = S_ISSUE;
        end else if (w_last_sweep) begin
          w_state_nxt = S_DONE;
        end else begin
          w_sweep_nxt = 8'(r_sweep + 8'd1);
          w_node_nxt  = w_hit_first[NODE_W-1:0];
          w_state_nxt = S_ISSUE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, run context and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_node      <= '0;
      r_sweep     <= '0;
      r_iter      <= '0;
      r_fixed     <= '0;
      r_selector  <= '0;
      r_upd_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_node   <= '0;
      r_wr_x      <= '0;
      r_wr_y      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_node      <= w_node_nxt;
      r_sweep     <= w_sweep_nxt;
      if (w_latch) begin
        r_iter  <= iterations;
        r_fixed <= fixed_mask;
      end
      r_selector  <= (w_state_nxt inside {S_ISSUE, S_WAIT, S_WRITE}) ?
                     (width'(1) << w_node_nxt) : '0;
      r_upd_valid <= (w_state_nxt == S_ISSUE);
      r_wr_en     <= (w_state_nxt == S_WRITE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      if ((r_state == S_WAIT) && res_valid) begin
        r_wr_node <= r_node;
        r_wr_x    <= res_x;
        r_wr_y    <= res_y;
      end
    end
  end

  assign selector  = r_selector;
  assign upd_valid = r_upd_valid;
  assign wr_en     = r_wr_en;
  assign wr_node   = r_wr_node;
  assign wr_x      = r_wr_x;
  assign wr_y      = r_wr_y;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sweep_cnt = r_sweep;

endmodule

// File: tb/tb_node_update_scheduler.sv
// Self-checking bench for node_update_scheduler: a sweep-list model drives a randomized update unit.
module tb_node_update_scheduler;

  localparam int unsigned W = 32;
  localparam int unsigned N = 5;
`ifdef NODE_SCHED_SKIP_FIXED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clk, rst_n, start, upd_ready, res_valid;
  logic [7:0]   iterations;
  logic [N-1:0] fixed_mask;
  logic [W-1:0] res_x, res_y;
  logic [W-1:0] selector, wr_x, wr_y;
  logic         upd_valid, wr_en, busy, done;
  logic [7:0]   wr_node, sweep_cnt;

  int checks   = 0;
  int failures = 0;

  node_update_scheduler #(.width(W), .node_contains(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iterations(iterations),
    .fixed_mask(fixed_mask), .selector(selector), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .res_valid(res_valid), .res_x(res_x), .res_y(res_y),
    .wr_en(wr_en), .wr_node(wr_node), .wr_x(wr_x), .wr_y(wr_y),
    .busy(busy), .done(done), .sweep_cnt(sweep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},   64'(selector),  64'd0);
    chk({tag, "_uv"},    64'(upd_valid), 64'd0);
    chk({tag, "_wren"},  64'(wr_en),     64'd0);
    chk({tag, "_wnode"}, 64'(wr_node),   64'd0);
    chk({tag, "_wx"},    64'(wr_x),      64'd0);
    chk({tag, "_wy"},    64'(wr_y),      64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
    chk({tag, "_sweep"}, 64'(sweep_cnt), 64'd0);
  endtask

  // One run: model = ordered list of (sweep, node) writebacks; the bench plays the update unit.
  task automatic run(input int iter, input logic [N-1:0] mask, input bit rnd, input int hold_node);
    int           exp_node[$];
    int           exp_sweep[$];
    logic [W-1:0] ex_x, ex_y, exp_sel;
    int           len, cyc, rdy_wait, res_wait, hold_left;
    bit           waiting, finished, held_once;

    for (int s = 0; s < iter; s++)
      for (int n = 0; n < int'(N); n++)
        if (!(SKIP && mask[n])) begin
          exp_node.push_back(n);
          exp_sweep.push_back(s);
        end
    len = exp_node.size();

    @(negedge clk);
    start = 1'b1; iterations = 8'(iter); fixed_mask = mask;
    upd_ready = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; waiting = 1'b0; finished = 1'b0; held_once = 1'b0; hold_left = 0;
    rdy_wait = rnd ? int'($urandom_range(0, 3)) : 0;
    res_wait = 0; ex_x = '0; ex_y = '0;

    while (!finished && cyc < 3000) begin
      chk("busy_in_run", 64'(busy), 64'd1);
      upd_ready = 1'b0;
      res_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      res_x = $urandom; res_y = $urandom;
      if (done) begin
        finished = 1'b1;
        chk("done_queue_empty", 64'(exp_node.size()), 64'd0);
        chk("done_sweep_cnt",   64'(sweep_cnt), 64'((len == 0) ? 0 : iter - 1));
        chk("done_sel",         64'(selector),  64'd0);
        chk("done_uv",          64'(upd_valid), 64'd0);
        chk("done_wren",        64'(wr_en),     64'd0);
        if (!rnd && hold_node < 0) chk("done_latency", 64'(cyc), 64'(3 * len + 1));
        start = 1'b0;
      end else if (exp_node.size() == 0) begin
        chk("activity_after_last_write", 64'(upd_valid | wr_en), 64'd0);
        chk("missing_done", 64'(done), 64'd1);
        finished = 1'b1;
      end else begin
        exp_sel = W'(1) << exp_node[0];
        chk("selector", 64'(selector), 64'(exp_sel));
        if (wr_en) begin
          chk("wr_node",   64'(wr_node),   64'(exp_node[0]));
          chk("wr_x",      64'(wr_x),      64'(ex_x));
          chk("wr_y",      64'(wr_y),      64'(ex_y));
          chk("wr_sweep",  64'(sweep_cnt), 64'(exp_sweep[0]));
          chk("wr_uv_low", 64'(upd_valid), 64'd0);
          void'(exp_node.pop_front());
          void'(exp_sweep.pop_front());
          waiting = 1'b0;
        end else if (upd_valid) begin
          chk("issue_not_waiting", 64'(waiting), 64'd0);
          if (!held_once && exp_node[0] == hold_node) begin
            held_once = 1'b1;
            hold_left = 4;
          end
          if (hold_left > 0) begin
            hold_left--;
          end else if (rdy_wait > 0) begin
            rdy_wait--;
          end else begin
            upd_ready = 1'b1;
            waiting   = 1'b1;
            res_wait  = rnd ? int'($urandom_range(0, 3)) : 0;
            rdy_wait  = rnd ? int'($urandom_range(0, 3)) : 0;
            ex_x = $urandom; ex_y = $urandom;
          end
        end else begin
          chk("wait_phase", 64'(waiting), 64'd1);
          if (res_wait > 0) begin
            res_wait--;
            res_valid = 1'b0;
          end else begin
            res_valid = 1'b1; res_x = ex_x; res_y = ex_y;
          end
        end
      end
      if (!finished) begin
        start = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (rnd) begin
          iterations = 8'($urandom);
          fixed_mask = N'($urandom);
        end
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) chk("run_timeout", 64'd1, 64'd0);
    start = 1'b0; res_valid = 1'b0; upd_ready = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_sel",  64'(selector), 64'd0);
  endtask

  // Reset while waiting on node 3: outputs clear at once and node 3 is never written.
  task automatic reset_in_wait();
    bit found;
    @(negedge clk);
    start = 1'b1; iterations = 8'd1; fixed_mask = '0;
    upd_ready = 1'b1; res_valid = 1'b1; res_x = 32'h1234_5678; res_y = 32'h9abc_def0;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (upd_valid && selector == W'(8)) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_issue_node3", 64'(found), 64'd1);
    res_valid = 1'b0;
    @(negedge clk);
    chk("wait3_uv",  64'(upd_valid), 64'd0);
    chk("wait3_sel", 64'(selector),  64'd8);
    res_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    chk("rst_no_write", 64'(wr_en), 64'd0);
    rst_n = 1'b1;
    res_valid = 1'b0; upd_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_wren", 64'(wr_en), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; iterations = '0; fixed_mask = '0;
    upd_ready = 1'b0; res_valid = 1'b0; res_x = '0; res_y = '0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 64'(busy), 64'd0);

    run(1, '0, 1'b0, -1);
    run(3, '0, 1'b0, -1);
    run(1, '0, 1'b0, 2);
    reset_in_wait();
    run(1, '0, 1'b0, -1);
    run(0, 5'b01101, 1'b0, -1);
    run(1, 5'b10101, 1'b0, -1);
    run(2, 5'b10101, 1'b0, -1);
    run(2, 5'b11111, 1'b0, -1);
    for (int k = 0; k < 12; k++)
      run(int'($urandom_range(0, 4)), N'($urandom), 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
